// File: rtl/median_window_feeder.sv
// Raster-order 3x3 window feeder for the MEDIAN serial filter: fetches each edge-replicated
// neighbourhood, streams it under MED_DSI and presents MED_DO on a valid/ready port.
// Optional `MEDIAN_FEEDER_TIMEOUT_EN adds the ERR output and a MED_DSO watchdog.
module median_window_feeder #(
  parameter int unsigned W       = 256,
  parameter int unsigned H       = 256,
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
  output logic                 ERR,
`endif
  output logic [AW-1:0]        MEM_ADDR,
  output logic                 MEM_RD,
  input  logic [7:0]           MEM_RDATA,
  output logic [7:0]           MED_DI,
  output logic                 MED_DSI,
  input  logic [7:0]           MED_DO,
  input  logic                 MED_DSO,
  output logic [7:0]           PIX_OUT,
  output logic [$clog2(W)-1:0] PIX_X,
  output logic [$clog2(H)-1:0] PIX_Y,
  output logic                 PIX_VALID,
  input  logic                 PIX_READY
);

  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam logic [XW-1:0] XMAX = XW'(W - 1);
  localparam logic [YW-1:0] YMAX = YW'(H - 1);

  if (W < 2 || H < 2 || TIMEOUT < 1 ||
      (longint'(W) * longint'(H)) > (longint'(1) << AW)) begin : g_bad_params
    $error("median_window_feeder: invalid W/H/AW/TIMEOUT");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StWaitDso,
    StOutput
  } state_e;

  state_e          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [3:0]      tap_q;

  logic            x_last;
  logic            y_last;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q;
`endif

  // Clamping happens on the coordinates before the multiply, so the address never wraps.
  function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] cx, input logic [YW-1:0] cy,
                                             input logic [3:0] k);
    int unsigned row, col, rx, ry;
    row = 32'(k) / 3;
    col = 32'(k) % 3;
    if (col == 0)      rx = (cx == '0) ? 32'd0 : 32'(cx) - 32'd1;
    else if (col == 1) rx = 32'(cx);
    else               rx = (cx == XMAX) ? W - 1 : 32'(cx) + 32'd1;
    if (row == 0)      ry = (cy == '0) ? 32'd0 : 32'(cy) - 32'd1;
    else if (row == 1) ry = 32'(cy);
    else               ry = (cy == YMAX) ? H - 1 : 32'(cy) + 32'd1;
    return AW'(ry * W + rx);
  endfunction

  always_comb begin
    x_last = (x_q == XMAX);
    y_last = (y_q == YMAX);
    nx     = x_last ? '0 : x_q + XW'(1);
    ny     = x_last ? y_q + YW'(1) : y_q;
  end

  // MEM_RDATA is already the memory's output register; gating keeps MED_DI quiet between taps.
  assign MED_DI = MED_DSI ? MEM_RDATA : 8'h00;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      tap_q     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_RD    <= 1'b0;
      MED_DSI   <= 1'b0;
      PIX_OUT   <= '0;
      PIX_X     <= '0;
      PIX_Y     <= '0;
      PIX_VALID <= 1'b0;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
      ERR       <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      DONE    <= 1'b0;
      MED_DSI <= MEM_RD;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            BUSY     <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            tap_q    <= '0;
            MEM_RD   <= 1'b1;
            MEM_ADDR <= tap_addr('0, '0, 4'd0);
            state_q  <= StFetch;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
            ERR      <= 1'b0;
`endif
          end
        end
        StFetch: begin
          if (tap_q == 4'd8) begin
            MEM_RD  <= 1'b0;
            state_q <= StLast;
          end else begin
            tap_q    <= tap_q + 4'd1;
            MEM_ADDR <= tap_addr(x_q, y_q, tap_q + 4'd1);
          end
        end
        StLast: begin
          state_q <= StWaitDso;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StWaitDso: begin
          if (MED_DSO) begin
            PIX_OUT   <= MED_DO;
            PIX_X     <= x_q;
            PIX_Y     <= y_q;
            PIX_VALID <= 1'b1;
            state_q   <= StOutput;
          end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            ERR     <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        StOutput: begin
          if (PIX_READY) begin
            PIX_VALID <= 1'b0;
            x_q       <= nx;
            y_q       <= ny;
            if (x_last && y_last) begin
              DONE    <= 1'b1;
              BUSY    <= 1'b0;
              state_q <= StIdle;
            end else begin
              tap_q    <= '0;
              MEM_RD   <= 1'b1;
              MEM_ADDR <= tap_addr(nx, ny, 4'd0);
              state_q  <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
Initiator for the MEDIAN serial 3x3 filter interface. Walks a W x H 8-bit image held in a synchronous-read pixel memory in raster order. For each pixel it fetches the 3x3 neighbourhood with edge replication and streams the 9 taps to MEDIAN under DSI. It then waits for DSO, captures DO and presents the filtered pixel on a valid/ready output port.

Parameters:
W, 256, image width in pixels (>=2)
H, 256, image height in pixels (>=2)
AW, 16, memory address width; W*H <= 2**AW
TIMEOUT, 1023, max cycles waited for MED_DSO (used only with the optional feature)

Ports:
CLK  in  1  clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
START  in  1  1-cycle pulse; starts one frame when idle
BUSY  out  1  high from accepted START until DONE
DONE  out  1  1-cycle pulse after the last output pixel is accepted
MEM_ADDR  out  AW  pixel read address = ry*W + rx
MEM_RD  out  1  read strobe
MEM_RDATA  in  8  read data, valid the cycle after MEM_RD
MED_DI  out  8  tap data to MEDIAN
MED_DSI  out  1  tap strobe to MEDIAN
MED_DO  in  8  MEDIAN result
MED_DSO  in  1  MEDIAN result valid
PIX_OUT  out  8  filtered pixel
PIX_X  out  log2(W)  x coordinate of PIX_OUT
PIX_Y  out  log2(H)  y coordinate of PIX_OUT
PIX_VALID  out  1  PIX_OUT/PIX_X/PIX_Y valid
PIX_READY  in  1  downstream accepts when PIX_VALID & PIX_READY

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; x = y = 0. Reset mid-frame aborts the frame immediately; no partial output follows.
- FSM states: IDLE, FETCH, LAST, WAIT_DSO, OUTPUT.
- IDLE: START=1 -> FETCH, BUSY=1, x = y = 0. START in any other state is ignored.
- FETCH: 9 consecutive cycles with MEM_RD=1, taps k=0..8.
  - Tap k: i = k/3 - 1, j = k%3 - 1.
  - Coordinates: rx = clamp(x+j, 0, W-1), ry = clamp(y+i, 0, H-1).
  - After tap 8 -> LAST.
- Data path: MEM_RDATA is registered into MED_DI with MED_DSI=1 on the cycle after each read. Result: MED_DSI is high for exactly 9 consecutive cycles, lagging MEM_RD by 1 cycle.
- LAST: delivers tap 8 to MEDIAN, then -> WAIT_DSO. MED_DSI=0 from WAIT_DSO onward. MED_DSI is always low for at least 1 cycle between windows.
- WAIT_DSO: on the first rising edge with MED_DSO=1:
  - capture MED_DO into PIX_OUT; latch x, y into PIX_X, PIX_Y;
  - PIX_VALID=1; -> OUTPUT.
  - MED_DSO is ignored in every other state.
- OUTPUT: PIX_VALID and data are held stable until PIX_READY=1. On acceptance:
  - PIX_VALID=0.
  - Advance x; on x = W-1, x = 0 and y++.
  - Pixel (W-1, H-1) accepted -> DONE pulse, BUSY=0, IDLE.
  - Otherwise -> FETCH in the next cycle.
- No new MEM_RD is issued while a result is pending. Throughput is at most 1 pixel per (11 + MEDIAN latency) cycles.
- Address arithmetic is unsigned; clamping is applied before the multiply, so no negative or overflowing address ever appears.

Optional Feature:
- Macro: MEDIAN_FEEDER_TIMEOUT_EN.
- Defined:
  - Adds output ERR (1 bit, reset 0) and a cycle counter in WAIT_DSO.
  - If MED_DSO is still not seen after TIMEOUT cycles: ERR=1 (sticky until reset or next accepted START), BUSY=0, no DONE, -> IDLE.
- Undefined: no ERR port; WAIT_DSO waits indefinitely.

Test Plan:
- W=H=4, START at (0,0) -> MEM_ADDR sequence 0,0,1,0,0,1,4,4,5; MED_DSI high exactly 9 cycles, one cycle behind MEM_RD.
- W=H=4, pixel (1,1) -> addresses 0,1,2,4,5,6,8,9,10. Pixel (3,3) -> 10,11,11,14,15,15,14,15,15.
- Behavioural MEDIAN model, 4x4 image with ramp values plus salt noise at (1,1)=255 -> all 16 PIX_OUT equal the software 3x3 replicated-edge median, in raster order. Then DONE 1 cycle; BUSY falls in the same cycle.
- PIX_READY low for 5 cycles on pixel (2,0) -> PIX_VALID, PIX_OUT, PIX_X=2 held; MEM_RD stays 0; a stray MED_DSO pulse is ignored.
- nRST asserted during FETCH of pixel (1,2) -> all outputs 0 asynchronously. A new START restarts at (0,0) with address sequence 0,0,1,0,0,1,4,4,5.
- MEDIAN_FEEDER_TIMEOUT_EN defined, TIMEOUT=20, MEDIAN model never asserts DSO -> ERR=1 exactly 20 cycles after entering WAIT_DSO, BUSY=0, DONE never pulses.
